// File: rtl/triggerrec_trigger_sequencer.sv
// Replays a timestamp-ordered trigger table from BRAM onto the IO pins.
// Each entry is fetched and armed, then fired when the timestamp reaches it. Playback can optionally loop.
module triggerrec_trigger_sequencer #(
  parameter int unsigned AW   = 5,
  parameter int unsigned TS_W = 48,
  parameter int unsigned IO_W = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 loop_en,
  input  logic [AW:0]          num_entries,
  input  logic [TS_W-1:0]      timestamp,
  output logic                 mem_rd_en,
  output logic [AW-1:0]        mem_rd_addr,
  input  logic [IO_W+TS_W-1:0] mem_rd_data,
  output logic [IO_W-1:0]      io_out,
  output logic                 fire,
  output logic                 busy,
  output logic                 done,
  output logic                 late,
  output logic [AW-1:0]        cur_idx
);

  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(1) << AW;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_ARMED = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e          state_q;
  logic [AW-1:0]   idx_q;
  logic [CW-1:0]   count_q;
  logic [IO_W-1:0] entry_val_q;
  logic [TS_W-1:0] entry_ts_q;
  logic            first_q;
  logic            mem_rd_en_q;
  logic [IO_W-1:0] io_out_q;
  logic            fire_q;
  logic            busy_q;
  logic            done_q;
  logic            late_q;

  logic [CW-1:0] count_clamp_c;
  logic [CW-1:0] idx_inc_c;
  logic          due_c;

  // Table length is capped at the physical table depth.
  assign count_clamp_c = (num_entries > MAX_CNT) ? MAX_CNT : num_entries;
  assign idx_inc_c     = CW'(idx_q) + CW'(1);
  assign due_c         = (timestamp >= entry_ts_q);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      count_q     <= '0;
      entry_val_q <= '0;
      entry_ts_q  <= '0;
      first_q     <= 1'b0;
      mem_rd_en_q <= 1'b0;
      io_out_q    <= '0;
      fire_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      late_q      <= 1'b0;
    end else begin
      mem_rd_en_q <= 1'b0;
      fire_q      <= 1'b0;
      if (stop) begin
        // Abort wins over everything, including a coincident start or a due entry.
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
        first_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (start) begin
              count_q <= count_clamp_c;
              idx_q   <= '0;
              late_q  <= 1'b0;
              if (count_clamp_c == '0) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
              end else begin
                state_q     <= S_FETCH;
                done_q      <= 1'b0;
                busy_q      <= 1'b1;
                mem_rd_en_q <= 1'b1;
              end
            end
          end
          S_FETCH: state_q <= S_WAIT;
          S_WAIT: begin
            entry_val_q <= mem_rd_data[IO_W+TS_W-1:TS_W];
            entry_ts_q  <= mem_rd_data[TS_W-1:0];
            first_q     <= 1'b1;
            state_q     <= S_ARMED;
          end
          S_ARMED: begin
            first_q <= 1'b0;
            if (first_q && (entry_ts_q < timestamp)) late_q <= 1'b1;
            if (due_c) begin
              io_out_q <= entry_val_q;
              fire_q   <= 1'b1;
              if (idx_inc_c < count_q) begin
                idx_q       <= idx_q + AW'(1);
                state_q     <= S_FETCH;
                mem_rd_en_q <= 1'b1;
              end else if (loop_en) begin
                idx_q       <= '0;
                state_q     <= S_FETCH;
                mem_rd_en_q <= 1'b1;
              end else begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
              end
            end
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign mem_rd_en   = mem_rd_en_q;
  assign mem_rd_addr = idx_q;
  assign io_out      = io_out_q;
  assign fire        = fire_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign late        = late_q;
  assign cur_idx     = idx_q;

endmodule
